// File: rtl/ex_mem_stage_if.sv
// EX->MEM pipeline bundle: EX-side capture inputs, hazard controls, and the
// registered MEM-side, flag and forwarding outputs of the stage.
interface ex_mem_stage_if #(
  parameter int WIDTH    = 64,
  parameter int REG_BITS = 5
);
  logic                stall;
  logic                flush;
  logic                ex_valid;
  logic [WIDTH-1:0]    ex_result;
  logic                ex_negative;
  logic                ex_zero;
  logic                ex_overflow;
  logic                ex_carry_out;
  logic                ex_set_flags;
  logic [WIDTH-1:0]    ex_store_data;
  logic [REG_BITS-1:0] ex_rd;
  logic                ex_reg_write;
  logic                ex_mem_read;
  logic                ex_mem_write;
  logic                ex_mem_to_reg;

  logic                mem_valid;
  logic [WIDTH-1:0]    mem_result;
  logic [WIDTH-1:0]    mem_store_data;
  logic [REG_BITS-1:0] mem_rd;
  logic                mem_reg_write;
  logic                mem_mem_read;
  logic                mem_mem_write;
  logic                mem_mem_to_reg;
  logic                flag_n;
  logic                flag_z;
  logic                flag_v;
  logic                flag_c;
  logic                cond_n;
  logic                cond_z;
  logic                cond_v;
  logic                cond_c;
  logic                fwd_valid;
  logic [REG_BITS-1:0] fwd_rd;

  modport master (
    output stall, flush, ex_valid, ex_result, ex_negative, ex_zero,
           ex_overflow, ex_carry_out, ex_set_flags, ex_store_data, ex_rd,
           ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg,
    input  mem_valid, mem_result, mem_store_data, mem_rd, mem_reg_write,
           mem_mem_read, mem_mem_write, mem_mem_to_reg, flag_n, flag_z,
           flag_v, flag_c, cond_n, cond_z, cond_v, cond_c, fwd_valid, fwd_rd
  );

  modport slave (
    input  stall, flush, ex_valid, ex_result, ex_negative, ex_zero,
           ex_overflow, ex_carry_out, ex_set_flags, ex_store_data, ex_rd,
           ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg,
    output mem_valid, mem_result, mem_store_data, mem_rd, mem_reg_write,
           mem_mem_read, mem_mem_write, mem_mem_to_reg, flag_n, flag_z,
           flag_v, flag_c, cond_n, cond_z, cond_v, cond_c, fwd_valid, fwd_rd
  );
endinterface

// File: rtl/ex_mem_stage.sv
// EX->MEM pipeline register with the architectural NZCV register, the
// same-cycle flag bypass for B.cond, and the EX->EX forwarding source.
module ex_mem_stage #(
  parameter int WIDTH    = 64,
  parameter int REG_BITS = 5
) (
  input  logic          clk,
  input  logic          reset,
  ex_mem_stage_if.slave bus
);
  localparam logic [REG_BITS-1:0] XZR = '1;

  logic                r_valid;
  logic [WIDTH-1:0]    r_result;
  logic [WIDTH-1:0]    r_store_data;
  logic [REG_BITS-1:0] r_rd;
  logic                r_reg_write;
  logic                r_mem_read;
  logic                r_mem_write;
  logic                r_mem_to_reg;
  logic [3:0]          r_nzvc;

  logic       w_reg_write;
  logic       w_mem_read;
  logic       w_mem_write;
  logic       w_mem_to_reg;
  logic       w_bypass;
  logic [3:0] w_alu_nzvc;
  logic [3:0] w_cond;

  // Control bits are sanitised before capture: bubbles carry no side effects
  // and XZR is never a write target.
  assign w_reg_write  = bus.ex_valid & bus.ex_reg_write & (bus.ex_rd != XZR);
  assign w_mem_read   = bus.ex_valid & bus.ex_mem_read;
  assign w_mem_write  = bus.ex_valid & bus.ex_mem_write;
  assign w_mem_to_reg = bus.ex_valid & bus.ex_mem_to_reg;
  assign w_alu_nzvc   = {bus.ex_negative, bus.ex_zero, bus.ex_overflow, bus.ex_carry_out};

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid      <= 1'b0;
      r_result     <= '0;
      r_store_data <= '0;
      r_rd         <= '0;
      r_reg_write  <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_to_reg <= 1'b0;
      r_nzvc       <= '0;
    end else if (bus.flush) begin
      // Bubble: flush beats stall; data and flags simply hold.
      r_valid      <= 1'b0;
      r_reg_write  <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_to_reg <= 1'b0;
    end else if (!bus.stall) begin
      r_valid      <= bus.ex_valid;
      r_result     <= bus.ex_result;
      r_store_data <= bus.ex_store_data;
      r_rd         <= bus.ex_rd;
      r_reg_write  <= w_reg_write;
      r_mem_read   <= w_mem_read;
      r_mem_write  <= w_mem_write;
      r_mem_to_reg <= w_mem_to_reg;
      if (bus.ex_valid && bus.ex_set_flags) begin
        r_nzvc <= w_alu_nzvc;
      end
    end
  end

  // A held (stalled) flag-setter still bypasses, so B.cond sees it early.
  assign w_bypass = bus.ex_valid & bus.ex_set_flags & ~bus.flush;

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    w_cond = r_nzvc;
    if (w_bypass) begin
      w_cond = w_alu_nzvc;
    end
  end

  assign bus.mem_valid      = r_valid;
  assign bus.mem_result     = r_result;
  assign bus.mem_store_data = r_store_data;
  assign bus.mem_rd         = r_rd;
  assign bus.mem_reg_write  = r_reg_write;
  assign bus.mem_mem_read   = r_mem_read;
  assign bus.mem_mem_write  = r_mem_write;
  assign bus.mem_mem_to_reg = r_mem_to_reg;

  assign {bus.flag_n, bus.flag_z, bus.flag_v, bus.flag_c} = r_nzvc;
  assign {bus.cond_n, bus.cond_z, bus.cond_v, bus.cond_c} = w_cond;

  // Loads cannot forward from here; their data only exists after MEM.
  assign bus.fwd_valid = r_valid & r_reg_write & ~r_mem_read;
  assign bus.fwd_rd    = r_rd;
endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed bench for ex_mem_stage: a vector table for single-cycle captures
// plus hand-written reset, stall/flush and reset-mid-stall sequences.
module tb_ex_mem_stage;
  localparam int WIDTH    = 64;
  localparam int REG_BITS = 5;

  logic clk;
  logic reset;

  ex_mem_stage_if #(.WIDTH(WIDTH), .REG_BITS(REG_BITS)) bus ();

  ex_mem_stage #(.WIDTH(WIDTH), .REG_BITS(REG_BITS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // ctrl / e_ctrl pack {reg_write, mem_read, mem_write, mem_to_reg}; nzvc packs {N,Z,V,C}.
  typedef struct {
    logic        v;
    logic [63:0] res;
    logic [63:0] sd;
    logic [4:0]  rd;
    logic [3:0]  ctrl;
    logic        sf;
    logic [3:0]  nzvc;
    logic [3:0]  e_cond;
    logic        e_mval;
    logic [63:0] e_res;
    logic [63:0] e_sd;
    logic [4:0]  e_rd;
    logic [3:0]  e_ctrl;
    logic        e_fwd;
    logic [3:0]  e_flags;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] ctrl_out();
    return {bus.mem_reg_write, bus.mem_mem_read, bus.mem_mem_write, bus.mem_mem_to_reg};
  endfunction

  function automatic logic [3:0] flags_out();
    return {bus.flag_n, bus.flag_z, bus.flag_v, bus.flag_c};
  endfunction

  function automatic logic [3:0] cond_out();
    return {bus.cond_n, bus.cond_z, bus.cond_v, bus.cond_c};
  endfunction

  task automatic drive(input logic v, input logic [63:0] res, input logic [63:0] sd,
                       input logic [4:0] rd, input logic [3:0] ctrl, input logic sf,
                       input logic [3:0] nzvc);
    bus.ex_valid      = v;
    bus.ex_result     = res;
    bus.ex_store_data = sd;
    bus.ex_rd         = rd;
    {bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write, bus.ex_mem_to_reg} = ctrl;
    bus.ex_set_flags  = sf;
    {bus.ex_negative, bus.ex_zero, bus.ex_overflow, bus.ex_carry_out} = nzvc;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    //        v  res                    sd                     rd  ctrl     sf nzvc     | cond    mv res                    sd                     rd  ctrl     fwd flags
    vecs[0] = '{1'b1, 64'h1111_1111_1111_1111, 64'h0, 5'd3,  4'b1000, 1'b0, 4'b0000, 4'b0000, 1'b1, 64'h1111_1111_1111_1111, 64'h0, 5'd3,  4'b1000, 1'b1, 4'b0000};
    vecs[1] = '{1'b1, 64'hA, 64'h0, 5'd31, 4'b1000, 1'b0, 4'b0000, 4'b0000, 1'b1, 64'hA, 64'h0, 5'd31, 4'b0000, 1'b0, 4'b0000};
    vecs[2] = '{1'b1, 64'h100, 64'h0, 5'd5, 4'b1101, 1'b0, 4'b0000, 4'b0000, 1'b1, 64'h100, 64'h0, 5'd5, 4'b1101, 1'b0, 4'b0000};
    vecs[3] = '{1'b1, 64'h200, 64'hDEAD_BEEF, 5'd7, 4'b0010, 1'b0, 4'b0000, 4'b0000, 1'b1, 64'h200, 64'hDEAD_BEEF, 5'd7, 4'b0010, 1'b0, 4'b0000};
    vecs[4] = '{1'b0, 64'h300, 64'h0, 5'd9, 4'b1111, 1'b1, 4'b1111, 4'b0000, 1'b0, 64'h300, 64'h0, 5'd9, 4'b0000, 1'b0, 4'b0000};
    vecs[5] = '{1'b1, 64'h0, 64'h0, 5'd2, 4'b1000, 1'b1, 4'b0101, 4'b0101, 1'b1, 64'h0, 64'h0, 5'd2, 4'b1000, 1'b1, 4'b0101};
    vecs[6] = '{1'b1, 64'h5, 64'h0, 5'd4, 4'b1000, 1'b0, 4'b1010, 4'b0101, 1'b1, 64'h5, 64'h0, 5'd4, 4'b1000, 1'b1, 4'b0101};
    vecs[7] = '{1'b1, 64'h8000_0000_0000_0000, 64'h0, 5'd6, 4'b1000, 1'b1, 4'b1010, 4'b1010, 1'b1, 64'h8000_0000_0000_0000, 64'h0, 5'd6, 4'b1000, 1'b1, 4'b1010};
    vecs[8] = '{1'b1, 64'h1, 64'h0, 5'd8, 4'b1000, 1'b1, 4'b0001, 4'b0001, 1'b1, 64'h1, 64'h0, 5'd8, 4'b1000, 1'b1, 4'b0001};

    // Reset held for two edges with random inputs.
    reset = 1'b1;
    bus.stall = 1'($urandom);
    bus.flush = 1'($urandom);
    drive(1'($urandom), {$urandom, $urandom}, {$urandom, $urandom}, 5'($urandom),
          4'($urandom), 1'($urandom), 4'($urandom));
    step();
    drive(1'($urandom), {$urandom, $urandom}, {$urandom, $urandom}, 5'($urandom),
          4'($urandom), 1'($urandom), 4'($urandom));
    step();
    check("rst_mem_valid", 64'(bus.mem_valid), 64'd0);
    check("rst_mem_result", bus.mem_result, 64'd0);
    check("rst_mem_store_data", bus.mem_store_data, 64'd0);
    check("rst_mem_rd", 64'(bus.mem_rd), 64'd0);
    check("rst_ctrl", 64'(ctrl_out()), 64'd0);
    check("rst_flags", 64'(flags_out()), 64'd0);
    check("rst_fwd_valid", 64'(bus.fwd_valid), 64'd0);
    reset = 1'b0;
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    drive(1'b0, 64'h0, 64'h0, 5'd0, 4'b0000, 1'b0, 4'b0000);
    #1;
    check("rst_cond", 64'(cond_out()), 64'd0);

    // Table: one capture per vector, no stall or flush.
    for (int i = 0; i < 9; i++) begin
      drive(vecs[i].v, vecs[i].res, vecs[i].sd, vecs[i].rd, vecs[i].ctrl, vecs[i].sf, vecs[i].nzvc);
      #1;
      check($sformatf("v%0d_cond", i), 64'(cond_out()), 64'(vecs[i].e_cond));
      step();
      check($sformatf("v%0d_mem_valid", i), 64'(bus.mem_valid), 64'(vecs[i].e_mval));
      check($sformatf("v%0d_mem_result", i), bus.mem_result, vecs[i].e_res);
      check($sformatf("v%0d_mem_store_data", i), bus.mem_store_data, vecs[i].e_sd);
      check($sformatf("v%0d_mem_rd", i), 64'(bus.mem_rd), 64'(vecs[i].e_rd));
      check($sformatf("v%0d_ctrl", i), 64'(ctrl_out()), 64'(vecs[i].e_ctrl));
      check($sformatf("v%0d_fwd_valid", i), 64'(bus.fwd_valid), 64'(vecs[i].e_fwd));
      check($sformatf("v%0d_fwd_rd", i), 64'(bus.fwd_rd), 64'(vecs[i].e_rd));
      check($sformatf("v%0d_flags", i), 64'(flags_out()), 64'(vecs[i].e_flags));
    end

    // Capture A, then stall three cycles while presenting a flag-setting B.
    drive(1'b1, 64'd15, 64'h0, 5'd10, 4'b1000, 1'b0, 4'b0000);
    step();
    check("stall_a_result", bus.mem_result, 64'd15);
    bus.stall = 1'b1;
    drive(1'b1, 64'd99, 64'h0, 5'd11, 4'b1000, 1'b1, 4'b1000);
    for (int c = 0; c < 3; c++) begin
      #1;
      check($sformatf("stall%0d_cond_bypass", c), 64'(cond_out()), 64'(4'b1000));
      step();
      check($sformatf("stall%0d_mem_result", c), bus.mem_result, 64'd15);
      check($sformatf("stall%0d_mem_rd", c), 64'(bus.mem_rd), 64'd10);
      check($sformatf("stall%0d_mem_valid", c), 64'(bus.mem_valid), 64'd1);
      check($sformatf("stall%0d_flags", c), 64'(flags_out()), 64'(4'b0001));
    end

    // Stall and flush together: bubble, flushed ADDS must not touch flags.
    bus.flush = 1'b1;
    #1;
    check("flush_cond_no_bypass", 64'(cond_out()), 64'(4'b0001));
    step();
    check("flush_mem_valid", 64'(bus.mem_valid), 64'd0);
    check("flush_ctrl", 64'(ctrl_out()), 64'd0);
    check("flush_fwd_valid", 64'(bus.fwd_valid), 64'd0);
    check("flush_flags", 64'(flags_out()), 64'(4'b0001));
    check("flush_flag_n", 64'(bus.flag_n), 64'd0);
    bus.stall = 1'b0;
    bus.flush = 1'b0;

    // Reset arriving while a valid writer is held by stall.
    drive(1'b1, 64'h77, 64'h0, 5'd12, 4'b1000, 1'b0, 4'b0000);
    step();
    check("mid_capture_valid", 64'(bus.mem_valid), 64'd1);
    bus.stall = 1'b1;
    step();
    check("mid_held_reg_write", 64'(bus.mem_reg_write), 64'd1);
    reset = 1'b1;
    step();
    check("mid_rst_mem_valid", 64'(bus.mem_valid), 64'd0);
    check("mid_rst_reg_write", 64'(bus.mem_reg_write), 64'd0);
    check("mid_rst_fwd_valid", 64'(bus.fwd_valid), 64'd0);
    check("mid_rst_flags", 64'(flags_out()), 64'd0);
    reset = 1'b0;
    bus.stall = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/ex_mem_stage.md
# ex_mem_stage

Execute-to-memory pipeline stage of the 64-bit pipelined ARM CPU. It captures the ALU result, ALU flags, store data and destination/control bits at the end of EX and presents them to MEM one cycle later. It also holds the architectural NZCV flag register and drives the EX→EX forwarding source. It sits directly downstream of the 64-bit ALU (AND/OR/ADD/SUB/shift units) and upstream of data memory.

## Interface
- `WIDTH`, 64, datapath width (result, store data)
- `REG_BITS`, 5, register index width; index 31 is XZR
- `clk`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-high; sampled on the rising edge of `clk`
- `stall`  in  1  hold stage contents, from hazard unit
- `flush`  in  1  squash the incoming instruction, from branch resolution
- `ex_valid`  in  1  EX holds a real instruction
- `ex_result`  in  WIDTH  ALU result
- `ex_negative`, `ex_zero`, `ex_overflow`, `ex_carry_out`  in  1 each  ALU flags
- `ex_set_flags`  in  1  instruction is flag-setting (ADDS/SUBS)
- `ex_store_data`  in  WIDTH  register value for STUR
- `ex_rd`  in  REG_BITS  destination register
- `ex_reg_write`, `ex_mem_read`, `ex_mem_write`, `ex_mem_to_reg`  in  1 each  control bits
- `mem_valid`  out  1  MEM holds a real instruction
- `mem_result`, `mem_store_data`  out  WIDTH  registered copies
- `mem_rd`  out  REG_BITS  registered destination
- `mem_reg_write`, `mem_mem_read`, `mem_mem_write`, `mem_mem_to_reg`  out  1 each  registered control bits
- `flag_n`, `flag_z`, `flag_v`, `flag_c`  out  1 each  architectural NZCV register
- `cond_n`, `cond_z`, `cond_v`, `cond_c`  out  1 each  bypassed flags for B.cond in the next instruction
- `fwd_valid`  out  1  `mem_result` may be forwarded to EX
- `fwd_rd`  out  REG_BITS  register being forwarded

## Operation
- Capture enable: `cap = ~stall & ~flush`. Bubble: `flush` (`stall` is ignored).
- On capture, all `mem_*` registers load their `ex_*` inputs and `mem_valid <= ex_valid`.
- Control sanitising at capture:
  - If `ex_valid` = 0, all four control bits are forced to 0.
  - If `ex_rd` = 31, `mem_reg_write` is forced to 0 (XZR is never written).
- Stall: every register holds, including the flags and `mem_valid`.
- Flush: `mem_valid` and all four control bits become 0. The data registers (`mem_result`, `mem_store_data`, `mem_rd`) may load or hold; they are don't-care while invalid. The flags hold.
- Flag register: loads `{N,Z,V,C}` from the ALU when `cap & ex_valid & ex_set_flags`; otherwise holds.
- Bypass flags: `cond_*` equal the ALU flags when `ex_valid & ex_set_flags & ~flush`; otherwise they equal `flag_*`. This path is combinational.
- Forwarding:
  - `fwd_valid = mem_valid & mem_reg_write & ~mem_mem_read`. Load data is not available in this stage.
  - `fwd_rd = mem_rd`.
- No arithmetic is performed; every width is passed through unchanged.

## Timing
- Latency: 1 cycle, EX inputs → `mem_*` outputs.
- Reset: on the first rising edge with `reset` = 1, every registered output becomes 0: `mem_valid`, `mem_result`, `mem_store_data`, `mem_rd`, all control bits, and all `flag_*`.
  - Consequence: `fwd_valid` = 0 and `cond_*` = `flag_*` = 0 unless EX is driving a valid flag-setter.
- Reset priority: `reset` overrides `stall` and `flush`. A reset arriving mid-stall discards the held instruction.
- Stall and flush in the same cycle: flush wins and a bubble is inserted.
- Back-to-back flag-setters: the second overwrites the first on the next edge. `cond_*` always reflect the youngest flag-setter that is valid and not flushed.
- Stalled flag-setter: `flag_*` is not updated. `cond_*` still present the ALU flags while `ex_*` is held.

## Test plan
- Reset: hold `reset` for 2 cycles with random inputs → all `mem_*` = 0, `flag_*` = 0, `fwd_valid` = 0.
- Basic capture: `ex_valid`=1, `ex_result`=64'h1111_1111_1111_1111, `ex_rd`=3, `ex_reg_write`=1 → next cycle `mem_result`=64'h1111_1111_1111_1111, `mem_rd`=3, `fwd_valid`=1, `fwd_rd`=3.
- XZR and load:
  - `ex_rd`=31 with `ex_reg_write`=1 → `mem_reg_write`=0, `fwd_valid`=0.
  - `ex_mem_read`=1, `ex_rd`=5 → `fwd_valid`=0.
- Stall then flush:
  - Capture A (result 64'd15), then assert `stall` for 3 cycles while presenting B → `mem_result` stays 64'd15.
  - Then assert `stall` and `flush` together → `mem_valid`=0 and all control bits 0.
- Flags:
  - SUBS with Z=1, C=1 → `cond_z`=1 in the same cycle, `flag_z`=`flag_c`=1 next cycle.
  - A following non-flag-setting instruction leaves `flag_*` unchanged.
  - A flushed ADDS with N=1 → `flag_n` stays 0.
- Reset mid-stall: hold a valid `ex_reg_write` instruction under `stall`, pulse `reset` for 1 cycle → `mem_valid`=0 and `mem_reg_write`=0 on that edge.
